// File: rtl/router_out_arb_pkg.sv
// Shared router constants and types.
// Default fifo word width / input count used by both the fifo instances and
// the output arbiter, plus the source-index width helper.
package router_out_arb_pkg;

  localparam int unsigned ROUTER_DATA_WIDTH = 8;
  localparam int unsigned ROUTER_NUM_IN     = 4;

  // Width of an index that addresses n inputs (n >= 2).
  function automatic int unsigned src_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned ROUTER_SRC_W = src_w(ROUTER_NUM_IN);

  typedef logic [ROUTER_SRC_W-1:0] src_idx_t;

endpackage

// File: rtl/router_out_arb_if.sv
// Output-stage bus between the per-input fifos, the arbiter and the link.
//   in_empty  : fifo empty flags            (fifo    -> arbiter)
//   in_data   : fifo head words             (fifo    -> arbiter)
//   in_pop    : one-hot pop strobe          (arbiter -> fifo)
//   out_valid : output slot holds a word    (arbiter -> link)
//   out_data  : registered word             (arbiter -> link)
//   out_src   : fifo index of that word     (arbiter -> link)
//   out_ready : link accepts this cycle     (link    -> arbiter)
// master = arbiter side, slave = fifo/link environment.
interface router_out_arb_if
  import router_out_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = ROUTER_DATA_WIDTH,
  parameter int unsigned NUM_IN     = ROUTER_NUM_IN
);
  localparam int unsigned SRC_W = src_w(NUM_IN);

  logic [NUM_IN-1:0]                 in_empty;
  logic [NUM_IN-1:0][DATA_WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]                 in_pop;
  logic                              out_valid;
  logic [DATA_WIDTH-1:0]             out_data;
  logic [SRC_W-1:0]                  out_src;
  logic                              out_ready;

  modport master (
    input  in_empty, in_data, out_ready,
    output in_pop, out_valid, out_data, out_src
  );

  modport slave (
    output in_empty, in_data, out_ready,
    input  in_pop, out_valid, out_data, out_src
  );

endinterface

// File: rtl/router_out_arb_rr_arb.sv
// Round-robin arbiter with a registered last-grant pointer.
//   clk, rst_n  : clock, async active-low reset
//   req         : request vector
//   en          : grant may be consumed this cycle (pointer advances only then)
//   gnt_onehot  : one-hot grant, zero when !en or no request
//   gnt_idx     : index of the winning request (valid when any)
//   any         : at least one request present
// The search starts one past the last grant and wraps mod NUM_IN, so the
// input after the previous winner has highest priority.
module router_out_arb_rr_arb
  import router_out_arb_pkg::*;
#(
  parameter int unsigned NUM_IN = ROUTER_NUM_IN,
  localparam int unsigned IDX_W = src_w(NUM_IN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_IN-1:0] req,
  input  logic              en,
  output logic [NUM_IN-1:0] gnt_onehot,
  output logic [IDX_W-1:0]  gnt_idx,
  output logic              any
);

  logic [IDX_W-1:0] ptr_q, ptr_d;

  // (p + k) mod NUM_IN for p < NUM_IN, k <= NUM_IN: one conditional subtract.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] p,
                                                input int unsigned k);
    int unsigned s;
    s = 32'(p) + k;
    if (s >= NUM_IN) s = s - NUM_IN;
    return IDX_W'(s);
  endfunction

  // Walk from farthest to nearest candidate so the nearest requester wins.
  always_comb begin
    gnt_idx    = '0;
    any        = 1'b0;
    gnt_onehot = '0;
    ptr_d      = ptr_q;
    for (int unsigned k = NUM_IN; k >= 1; k--) begin
      if (req[wrap_add(ptr_q, k)]) begin
        gnt_idx = wrap_add(ptr_q, k);
        any     = 1'b1;
      end
    end
    if (en && any) begin
      gnt_onehot[gnt_idx] = 1'b1;
      ptr_d               = gnt_idx;
    end
  end

  // Reset pointer to the last input so input 0 is first in line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= IDX_W'(NUM_IN - 1);
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/router_out_arb.sv
// Router output stage: round-robin pop of the non-empty input fifos into a
// single-entry registered output slot with valid/ready toward the link.
//   clk   : clock, all state on posedge
//   rst_n : async active-low reset
//   bus   : fifo flags/data/pop and link valid/data/src/ready (master side)
// A new word is loaded whenever the slot is empty or being drained in the same
// cycle, giving one word per cycle and one cycle fifo-head-to-out latency.
module router_out_arb
  import router_out_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = ROUTER_DATA_WIDTH,
  parameter int unsigned NUM_IN     = ROUTER_NUM_IN,
  localparam int unsigned SRC_W     = src_w(NUM_IN)
) (
  input  logic              clk,
  input  logic              rst_n,
  router_out_arb_if.master  bus
);

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
  logic [SRC_W-1:0]      out_src_q,   out_src_d;

  logic                  can_load_c;
  logic                  arb_en_c;
  logic                  pop_c;
  logic [NUM_IN-1:0]     req_c;
  logic [NUM_IN-1:0]     gnt_onehot_c;
  logic [SRC_W-1:0]      gnt_idx_c;
  logic                  any_c;

  // Gating with rst_n keeps every pop strobe low while reset is held.
  assign can_load_c = !out_valid_q || bus.out_ready;
  assign arb_en_c   = can_load_c && rst_n;
  assign req_c      = ~bus.in_empty;
  assign pop_c      = arb_en_c && any_c;

  router_out_arb_rr_arb #(
    .NUM_IN (NUM_IN)
  ) u_rr_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req_c),
    .en         (arb_en_c),
    .gnt_onehot (gnt_onehot_c),
    .gnt_idx    (gnt_idx_c),
    .any        (any_c)
  );

  // Output slot next state: load wins over drain, otherwise hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (pop_c) begin
      out_valid_d = 1'b1;
      out_data_d  = bus.in_data[gnt_idx_c];
      out_src_d   = gnt_idx_c;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign bus.in_pop    = gnt_onehot_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;

endmodule

// File: tb/tb_router_out_arb.sv
// Bench for router_out_arb: array-backed fifo models feed the DUT, a
// reference model tracks the expected slot and pointer each cycle, and
// directed sequences pin literal values.
module tb_router_out_arb;
  import router_out_arb_pkg::*;

  localparam int NUM_IN = ROUTER_NUM_IN;
  localparam int DW     = ROUTER_DATA_WIDTH;
  localparam int DEPTH  = 64;

  logic clk;
  logic rst_n;
  logic out_ready;

  router_out_arb_if #(.DATA_WIDTH(DW), .NUM_IN(NUM_IN)) tif ();

  router_out_arb #(.DATA_WIDTH(DW), .NUM_IN(NUM_IN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (tif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream fifos
  logic [DW-1:0] mem [NUM_IN][DEPTH];
  int            rd  [NUM_IN];
  int            wr  [NUM_IN];

  for (genvar g = 0; g < NUM_IN; g++) begin : g_fifo
    assign tif.in_empty[g] = (rd[g] == wr[g]);
    assign tif.in_data[g]  = mem[g][rd[g] % DEPTH];
  end
  assign tif.out_ready = out_ready;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int i, input logic [DW-1:0] d);
    mem[i][wr[i] % DEPTH] = d;
    wr[i]++;
  endtask

  // Reference model: slot contents and last-granted input
  int            m_ptr;
  bit            m_valid;
  logic [DW-1:0] m_data;
  int            m_src;

  task automatic model_reset();
    m_ptr   = NUM_IN - 1;
    m_valid = 0;
    m_data  = '0;
    m_src   = 0;
  endtask

  always begin : model_chk
    logic [NUM_IN-1:0] exp_pop;
    logic [NUM_IN-1:0] dut_pop;
    logic [NUM_IN-1:0] emp;
    int                g;
    int                j;
    bit                can;
    bit                have;
    bit                n_valid;
    logic [DW-1:0]     n_data;
    int                n_src;
    int                n_ptr;
    @(negedge clk);
    have = 0;
    if (!rst_n) begin
      chk("rst_pop", 32'(tif.in_pop), 32'(0));
      chk("rst_valid", 32'(tif.out_valid), 32'(0));
    end else begin
      for (int i = 0; i < NUM_IN; i++) emp[i] = (rd[i] == wr[i]);
      can = !m_valid || out_ready;
      g   = -1;
      for (int k = 1; k <= NUM_IN; k++) begin
        j = (m_ptr + k) % NUM_IN;
        if (g < 0 && !emp[j]) g = j;
      end
      exp_pop = '0;
      if (can && g >= 0) exp_pop[g] = 1'b1;
      dut_pop = tif.in_pop;
      chk("in_pop", 32'(dut_pop), 32'(exp_pop));
      chk("pop_of_empty", 32'(dut_pop & emp), 32'(0));
      chk("out_valid", 32'(tif.out_valid), 32'(m_valid));
      chk("out_data", 32'(tif.out_data), 32'(m_data));
      chk("out_src", 32'(tif.out_src), 32'(m_src));
      n_valid = m_valid; n_data = m_data; n_src = m_src; n_ptr = m_ptr;
      if (can && g >= 0) begin
        n_valid = 1; n_data = mem[g][rd[g] % DEPTH]; n_src = g; n_ptr = g;
      end else if (m_valid && out_ready) begin
        n_valid = 0;
      end
      have = 1;
    end
    @(posedge clk);
    #1;
    if (!rst_n) begin
      model_reset();
    end else if (have) begin
      m_valid = n_valid; m_data = n_data; m_src = n_src; m_ptr = n_ptr;
      for (int i = 0; i < NUM_IN; i++)
        if (dut_pop[i] && rd[i] != wr[i]) rd[i]++;
    end
  end

  function automatic bit all_empty();
    for (int i = 0; i < NUM_IN; i++) if (rd[i] != wr[i]) return 0;
    return 1;
  endfunction

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((!all_empty() || tif.out_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(n < 100), 32'(1));
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < NUM_IN; i++) begin rd[i] = 0; wr[i] = 0; end
    model_reset();

    // 1: reset with every fifo non-empty
    for (int i = 0; i < NUM_IN; i++) begin
      push(i, 8'hA0 + 8'(i));
      push(i, 8'hA0 + 8'(i));
    end
    repeat (2) begin
      @(negedge clk);
      chk("t1_pop_in_reset", 32'(tif.in_pop), 32'(0));
      chk("t1_valid_in_reset", 32'(tif.out_valid), 32'(0));
    end
    after_edge();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t1_first_pop", 32'(tif.in_pop), 32'(4'b0001));

    // 2: all requesting -> A0,A1,A2,A3,A0 back to back
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t2_seq_data", 32'(tif.out_data), 32'(8'hA0 + 8'(k % 4)));
      chk("t2_one_pop", 32'($countones(tif.in_pop)), 32'(1));
    end
    drain();

    // 3: lone requester on input 2
    after_edge();
    for (int k = 0; k < 5; k++) push(2, 8'h20 + 8'(k));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t3_pop", 32'(tif.in_pop), 32'(4'b0100));
      if (k > 0) begin
        chk("t3_valid", 32'(tif.out_valid), 32'(1));
        chk("t3_src", 32'(tif.out_src), 32'(2));
        chk("t3_data", 32'(tif.out_data), 32'(8'h20 + 8'(k - 1)));
      end
    end
    @(negedge clk);
    chk("t3_last_data", 32'(tif.out_data), 32'(8'h24));
    drain();

    // 4: backpressure hold, then drain and reload together
    after_edge();
    out_ready = 1'b0;
    push(1, 8'h10); push(1, 8'h11); push(1, 8'h12);
    @(negedge clk);
    chk("t4_load_pop", 32'(tif.in_pop), 32'(4'b0010));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_stall_pop", 32'(tif.in_pop), 32'(0));
      chk("t4_stall_data", 32'(tif.out_data), 32'(8'h10));
      chk("t4_stall_src", 32'(tif.out_src), 32'(1));
    end
    after_edge();
    out_ready = 1'b1;
    @(negedge clk);
    chk("t4_reload_pop", 32'(tif.in_pop), 32'(4'b0010));
    @(negedge clk);
    chk("t4_reload_valid", 32'(tif.out_valid), 32'(1));
    chk("t4_reload_data", 32'(tif.out_data), 32'(8'h11));
    drain();

    // 5: move pointer to 3, then inputs 1 and 3 alternate with wrap
    after_edge();
    push(3, 8'h30);
    @(negedge clk);
    chk("t5_prime_pop", 32'(tif.in_pop), 32'(4'b1000));
    drain();
    after_edge();
    push(1, 8'h40); push(1, 8'h41);
    push(3, 8'h50); push(3, 8'h51);
    @(negedge clk);
    chk("t5_gnt_a", 32'(tif.in_pop), 32'(4'b0010));
    @(negedge clk);
    chk("t5_gnt_b", 32'(tif.in_pop), 32'(4'b1000));
    @(negedge clk);
    chk("t5_gnt_c", 32'(tif.in_pop), 32'(4'b0010));
    chk("t5_data_c", 32'(tif.out_data), 32'(8'h50));
    drain();

    // 6: asynchronous reset mid-burst
    after_edge();
    for (int i = 0; i < NUM_IN; i++)
      for (int k = 0; k < 3; k++) push(i, 8'h60 + 8'(i * 4 + k));
    @(negedge clk);
    chk("t6_pre_pop", 32'(tif.in_pop), 32'(4'b0001));
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 32'(tif.out_valid), 32'(0));
    chk("t6_async_pop", 32'(tif.in_pop), 32'(0));
    repeat (2) @(negedge clk);
    after_edge();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_restart_pop", 32'(tif.in_pop), 32'(4'b0001));
    drain();

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
